// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the elastic pipeline register chain.
//   DEFAULT_WIDTH : default data word width (32, the processor's word size)
//   occ_width()   : bit width needed to count 0..depth valid stages
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if: upstream and downstream handshake bundle of one chain.
//   in_valid/in_ready/in_data    : upstream side (word enters stage 0)
//   out_valid/out_ready/out_data : downstream side (word leaves stage DEPTH-1)
//   occupancy                    : number of valid stages in the chain
//
// Handshake: a word moves across a side at the falling clock edge where that
// side's valid and ready are both high. A producer holding valid=1 while
// ready=0 must keep valid high and its data unchanged until the transfer.
// Ready may depend combinationally on the other side's ready; valid never
// depends on ready.
//
// Modports: master = environment around the chain, slave = the chain itself.
interface pipe_reg_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1
);

  localparam int OCC_W = occ_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: one stage of the elastic chain (valid bit + data register).
//   clk        : clock, registers update on the falling edge
//   reset      : synchronous active-high reset
//   flush      : synchronous squash, same effect as reset
//   load       : stage may take its predecessor's content this edge
//   prev_valid : valid bit offered by the predecessor
//   prev_data  : data word offered by the predecessor
//   valid      : this stage holds a word
//   data       : this stage's data register
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(negedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= prev_valid;
      // A bubble moves forward but leaves the old word in place, so an
      // emptied output stage keeps showing its last word.
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic register chain with valid/ready
// handshake, flush and occupancy count. Registers update on the falling edge.
//   WIDTH, DEPTH, RESET_VAL : word width, stage count (>=1), clear value
//   clk   : clock (falling edge active)
//   reset : synchronous active-high reset, wins over flush
//   flush : synchronous squash of every stage; blocks input that cycle
//   bus   : handshake bundle (slave side), see pipe_reg_chain_if
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  pipe_reg_chain_if.slave bus
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic             tail_full;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  // rdy[i] = ~v[i] | rdy[i+1], unrolled: stage i can load unless every
  // stage from i to the output is full and the output is stalled. Walking
  // from the output end keeps the chain free of self-referencing vectors.
  always_comb begin
    tail_full = 1'b1;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      rdy[i]    = ~tail_full | bus.out_ready;
    end
  end

  assign bus.in_ready = rdy[0] & ~flush;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = v[DEPTH-1] & bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (rdy[0]),
        .prev_valid (in_xfer),
        .prev_data  (bus.in_data),
        .valid      (v[0]),
        .data       (d[0])
      );
    end else begin : g_body
      pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (rdy[i]),
        .prev_valid (v[i-1]),
        .prev_data  (d[i-1]),
        .valid      (v[i]),
        .data       (d[i])
      );
    end
  end

  // Occupancy tracks transfers rather than summing v[], so it is a plain
  // up/down counter independent of DEPTH.
  always_ff @(negedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign bus.occupancy = occ_q;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  // A stalled upstream word must stay presented and unchanged until it is
  // taken, unless a reset or flush squashes it.
  a_in_hold_stable : assert property (
    @(negedge clk)
    (bus.in_valid && !bus.in_ready && !reset && !flush)
      |=> (reset || flush || (bus.in_valid && $stable(bus.in_data)))
  );

  a_occ_range : assert property (
    @(negedge clk) disable iff (reset) (int'(occ_q) <= DEPTH)
  );

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: bench for pipe_reg_chain with a DEPTH=1 and a DEPTH=3
// instance sharing clock and reset. Inputs change half a cycle after the
// falling edge; outputs are sampled just after the rising edge.
module tb_pipe_reg_chain;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_out_data;
    int          exp_occ;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush1 = 1'b0;
  logic flush3 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(1)) bus1 ();
  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) bus3 ();

  pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .flush (flush1),
    .bus   (bus1)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) dut3 (
    .clk   (clk),
    .reset (reset),
    .flush (flush3),
    .bus   (bus3)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one active (falling) edge, then settle just after the rising edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                         input int e_occ);
    vec_t t;
    t.in_valid      = iv;
    t.in_data       = id;
    t.out_ready     = ordy;
    t.exp_in_ready  = e_ir;
    t.exp_out_valid = e_ov;
    t.exp_out_data  = e_od;
    t.exp_occ       = e_occ;
    vecs.push_back(t);
  endtask

  task automatic drive3(input logic iv, input logic [31:0] id, input logic ordy);
    bus3.in_valid  = iv;
    bus3.in_data   = id;
    bus3.out_ready = ordy;
  endtask

  // one random/drain cycle of dut3 against the queue model
  task automatic model_cycle(inout logic hold, input bit drain);
    logic        in_x;
    logic        out_x;
    logic [31:0] got;
    if (drain) begin
      bus3.in_valid  = 1'b0;
      bus3.out_ready = 1'b1;
    end else begin
      if (!hold) begin
        bus3.in_valid = ($urandom_range(0, 3) != 0);
        bus3.in_data  = $urandom;
      end
      bus3.out_ready = ($urandom_range(0, 2) != 0);
    end
    #1;
    in_x  = bus3.in_valid && bus3.in_ready;
    out_x = bus3.out_valid && bus3.out_ready;
    got   = bus3.out_data;
    @(negedge clk);
    if (out_x) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_extra: got word %h expected no word", got);
      end else begin
        check("rand_data", got, exp_q.pop_front());
      end
    end
    if (in_x) exp_q.push_back(bus3.in_data);
    hold = bus3.in_valid && !in_x;
    @(posedge clk);
    #1;
    check("rand_occ", 32'(bus3.occupancy), 32'(exp_q.size()));
    if (exp_q.size() == 0) check("rand_empty_valid", 32'(bus3.out_valid), 32'd0);
  endtask

  // test sequence
  initial begin
    logic hold;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    drive3(1'b0, 32'h0, 1'b0);

    // reset for two active edges
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst1_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst1_out_data", bus1.out_data, 32'h0000_0000);
    check("rst1_occ", 32'(bus1.occupancy), 32'd0);
    check("rst1_in_ready", 32'(bus1.in_ready), 32'd1);
    check("rst3_out_valid", 32'(bus3.out_valid), 32'd0);
    check("rst3_occ", 32'(bus3.occupancy), 32'd0);
    check("rst3_in_ready", 32'(bus3.in_ready), 32'd1);

    // DEPTH=1 acts as a negedge register; full + stalled blocks input
    bus1.in_valid = 1'b1; bus1.in_data = 32'h1234_5678; bus1.out_ready = 1'b1;
    tick();
    check("d1_reg_data0", bus1.out_data, 32'h1234_5678);
    check("d1_reg_valid0", 32'(bus1.out_valid), 32'd1);
    check("d1_reg_occ0", 32'(bus1.occupancy), 32'd1);
    bus1.in_data = 32'hDEAD_BEEF;
    #1;
    check("d1_pass_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    check("d1_reg_data1", bus1.out_data, 32'hDEAD_BEEF);
    check("d1_reg_occ1", 32'(bus1.occupancy), 32'd1);
    bus1.in_data = 32'hCAFE_F00D; bus1.out_ready = 1'b0;
    #1;
    check("d1_full_ready", 32'(bus1.in_ready), 32'd0);
    tick();
    check("d1_stall_data", bus1.out_data, 32'hDEAD_BEEF);
    bus1.out_ready = 1'b1;
    #1;
    check("d1_release_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    check("d1_release_data", bus1.out_data, 32'hCAFE_F00D);
    bus1.in_valid = 1'b0;
    tick();
    check("d1_empty_valid", 32'(bus1.out_valid), 32'd0);
    check("d1_empty_hold", bus1.out_data, 32'hCAFE_F00D);
    check("d1_empty_occ", 32'(bus1.occupancy), 32'd0);

    // DEPTH=3 vector table: in_valid, in_data, out_ready,
    //   exp in_ready (before edge), exp out_valid/out_data/occupancy (after)
    // streaming with out_ready=1
    add_vec(1, 32'h10, 1, 1, 0, 32'h00, 1);
    add_vec(1, 32'h14, 1, 1, 0, 32'h00, 2);
    add_vec(1, 32'h18, 1, 1, 1, 32'h10, 3);
    add_vec(1, 32'h1C, 1, 1, 1, 32'h14, 3);
    add_vec(0, 32'h00, 1, 1, 1, 32'h18, 2);
    add_vec(0, 32'h00, 1, 1, 1, 32'h1C, 1);
    add_vec(0, 32'h00, 1, 1, 0, 32'h1C, 0);
    // backpressure: three accepted, fourth waits for out_ready
    add_vec(1, 32'h01, 0, 1, 0, 32'h1C, 1);
    add_vec(1, 32'h02, 0, 1, 0, 32'h1C, 2);
    add_vec(1, 32'h03, 0, 1, 1, 32'h01, 3);
    add_vec(1, 32'h04, 0, 0, 1, 32'h01, 3);
    add_vec(1, 32'h04, 1, 1, 1, 32'h02, 3);
    add_vec(0, 32'h00, 1, 1, 1, 32'h03, 2);
    add_vec(0, 32'h00, 1, 1, 1, 32'h04, 1);
    add_vec(0, 32'h00, 1, 1, 0, 32'h04, 0);
    // bubble collapse: A, gap, B while stalled, then drain back to back
    add_vec(1, 32'h0A, 0, 1, 0, 32'h04, 1);
    add_vec(0, 32'h00, 0, 1, 0, 32'h04, 1);
    add_vec(1, 32'h0B, 0, 1, 1, 32'h0A, 2);
    add_vec(0, 32'h00, 0, 1, 1, 32'h0A, 2);
    add_vec(0, 32'h00, 1, 1, 1, 32'h0B, 1);
    add_vec(0, 32'h00, 1, 1, 0, 32'h0B, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive3(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(bus3.in_ready), 32'(vecs[i].exp_in_ready));
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus3.out_valid), 32'(vecs[i].exp_out_valid));
      check($sformatf("vec%0d_out_data", i), bus3.out_data, vecs[i].exp_out_data);
      check($sformatf("vec%0d_occ", i), 32'(bus3.occupancy), 32'(vecs[i].exp_occ));
    end

    // flush on a full chain with input and output both offered
    for (int i = 0; i < 3; i++) begin
      drive3(1'b1, 32'h21 + 32'(i), 1'b0);
      tick();
    end
    check("fl_full_occ", 32'(bus3.occupancy), 32'd3);
    drive3(1'b1, 32'h24, 1'b1);
    flush3 = 1'b1;
    #1;
    check("fl_in_ready", 32'(bus3.in_ready), 32'd0);
    tick();
    flush3 = 1'b0;
    drive3(1'b0, 32'h0, 1'b1);
    #1;
    check("fl_occ", 32'(bus3.occupancy), 32'd0);
    check("fl_out_valid", 32'(bus3.out_valid), 32'd0);
    check("fl_out_data", bus3.out_data, 32'h0);
    check("fl_after_ready", 32'(bus3.in_ready), 32'd1);
    drive3(1'b1, 32'h25, 1'b1);
    tick();
    drive3(1'b0, 32'h0, 1'b1);
    check("fl_new_gap0", 32'(bus3.out_valid), 32'd0);
    tick();
    check("fl_new_gap1", 32'(bus3.out_valid), 32'd0);
    tick();
    check("fl_new_valid", 32'(bus3.out_valid), 32'd1);
    check("fl_new_data", bus3.out_data, 32'h25);
    check("fl_new_occ", 32'(bus3.occupancy), 32'd1);
    tick();
    check("fl_drained", 32'(bus3.occupancy), 32'd0);

    // reset together with flush and a presented word, mid-stream
    drive3(1'b1, 32'h31, 1'b0);
    tick();
    drive3(1'b1, 32'h32, 1'b0);
    tick();
    check("rf_pre_occ", 32'(bus3.occupancy), 32'd2);
    drive3(1'b1, 32'h33, 1'b1);
    reset  = 1'b1;
    flush3 = 1'b1;
    tick();
    reset  = 1'b0;
    flush3 = 1'b0;
    drive3(1'b0, 32'h0, 1'b0);
    #1;
    check("rf_occ", 32'(bus3.occupancy), 32'd0);
    check("rf_out_valid", 32'(bus3.out_valid), 32'd0);
    check("rf_out_data", bus3.out_data, 32'h0);
    check("rf_in_ready", 32'(bus3.in_ready), 32'd1);
    check("rf_d1_out_data", bus1.out_data, 32'h0);

    // random valid/ready traffic against a queue model, then drain
    hold = 1'b0;
    for (int c = 0; c < 300; c++) model_cycle(hold, 1'b0);
    // a still-held word must stay presented, so let it in before draining
    for (int c = 0; c < 4 && hold; c++) begin
      bus3.out_ready = 1'b1;
      model_cycle(hold, 1'b0);
    end
    for (int c = 0; c < 6; c++) model_cycle(hold, 1'b1);
    check("drain_occ", 32'(bus3.occupancy), 32'd0);
    check("drain_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
